id_scoreboard: RTL and testbench

Parametrised register-hazard scoreboard for the decode stage of the RISC-V core, the successor to the hard-coded E/M/W compare chains.
- Tracks every in-flight register write by destination register, with its age in the pipeline and its remaining result latency.
- Covers a configurable number of source-read ports (e.g. 3 for F-extension fused ops) and a configurable forwarding depth.
- From this state it generates the decode stall and one forwarding-select code per read port.
- Sits between the control unit/regfile in ID and the ID→EX pipeline registers.

---
 rtl/id_scoreboard_if.sv | 27 ++
 rtl/id_scoreboard.sv | 99 +++++++++
 tb/tb_id_scoreboard.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/id_scoreboard_if.sv
// id_scoreboard_if: issue, read-port and hazard/forwarding signals between ID control and the scoreboard
interface id_scoreboard_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_RD_PORTS = 3,
  parameter int FWD_STAGES = 3,
  parameter int AGE_W = $clog2(FWD_STAGES + 1)
);
  logic issue_i;
  logic kill_i;
  logic freeze_i;
  logic issue_wr_i;
  logic [REG_ADDR_WIDTH-1:0] issue_waddr_i;
  logic [AGE_W-1:0] issue_lat_i;
  logic [NUM_RD_PORTS-1:0] rd_en_i;
  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] rd_addr_i;
  logic stall_o;
  logic [NUM_RD_PORTS*AGE_W-1:0] fwd_sel_o;
  logic [REG_ADDR_WIDTH:0] inflight_o;
  modport master (
    output issue_i, kill_i, freeze_i, issue_wr_i, issue_waddr_i, issue_lat_i, rd_en_i, rd_addr_i,
    input stall_o, fwd_sel_o, inflight_o
  );
  modport slave (
    input issue_i, kill_i, freeze_i, issue_wr_i, issue_waddr_i, issue_lat_i, rd_en_i, rd_addr_i,
    output stall_o, fwd_sel_o, inflight_o
  );
endinterface

// File: rtl/id_scoreboard.sv
// id_scoreboard: decode-stage register hazard scoreboard; define ID_SB_FWD_EN to enable forwarding (otherwise stall until writeback)
module id_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_RD_PORTS = 3,
  parameter int FWD_STAGES = 3,
  parameter int AGE_W = $clog2(FWD_STAGES + 1)
) (
  input logic clk,
  input logic rst,
  id_scoreboard_if.slave sb
);
  localparam int NREG = 1 << REG_ADDR_WIDTH;
  localparam logic [AGE_W-1:0] LAST_AGE = AGE_W'(FWD_STAGES);
  logic [NREG-1:0] valid_q, valid_d;
  logic [AGE_W-1:0] age_q [NREG];
  logic [AGE_W-1:0] age_d [NREG];
  logic [REG_ADDR_WIDTH:0] inflight_q, inflight_d;
  logic [REG_ADDR_WIDTH-1:0] rd_a [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] rd_hit;
  logic [NUM_RD_PORTS-1:0] hazard;
  logic [NUM_RD_PORTS*AGE_W-1:0] fwd_sel;
  logic stall;
  logic alloc;
`ifdef ID_SB_FWD_EN
  localparam logic [AGE_W-1:0] MAX_CNT = AGE_W'(FWD_STAGES - 1);
  logic [AGE_W-1:0] cnt_q [NREG];
  logic [AGE_W-1:0] cnt_d [NREG];
  logic [AGE_W-1:0] alloc_cnt;
  assign alloc_cnt = (sb.issue_lat_i > MAX_CNT) ? MAX_CNT : sb.issue_lat_i;
`else
  logic [AGE_W-1:0] unused_lat;
  assign unused_lat = sb.issue_lat_i;
`endif
  for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_port
    assign rd_a[g] = sb.rd_addr_i[g*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign rd_hit[g] = sb.rd_en_i[g] & (rd_a[g] != '0) & valid_q[rd_a[g]];
`ifdef ID_SB_FWD_EN
    assign hazard[g] = rd_hit[g] & (cnt_q[rd_a[g]] != '0);
    assign fwd_sel[g*AGE_W +: AGE_W] = rd_hit[g] ? age_q[rd_a[g]] : '0;
`else
    assign hazard[g] = rd_hit[g];
    assign fwd_sel[g*AGE_W +: AGE_W] = '0;
`endif
  end
  assign stall = |hazard;
  assign sb.stall_o = stall;
  assign sb.fwd_sel_o = fwd_sel;
  assign sb.inflight_o = inflight_q;
  // allocate the accepted writer (newest wins), age everything else, retire entries leaving the last stage
  always_comb begin
    alloc = sb.issue_i & ~sb.kill_i & ~stall & ~sb.freeze_i & sb.issue_wr_i & (sb.issue_waddr_i != '0);
    inflight_d = '0;
    for (int r = 0; r < NREG; r++) begin
      valid_d[r] = valid_q[r];
      age_d[r] = age_q[r];
`ifdef ID_SB_FWD_EN
      cnt_d[r] = cnt_q[r];
`endif
      if (!sb.freeze_i) begin
        if (alloc && sb.issue_waddr_i == REG_ADDR_WIDTH'(r)) begin
          valid_d[r] = 1'b1;
          age_d[r] = AGE_W'(1);
`ifdef ID_SB_FWD_EN
          cnt_d[r] = alloc_cnt;
`endif
        end else if (valid_q[r]) begin
          valid_d[r] = age_q[r] != LAST_AGE;
          age_d[r] = (age_q[r] == LAST_AGE) ? '0 : age_q[r] + AGE_W'(1);
`ifdef ID_SB_FWD_EN
          cnt_d[r] = (age_q[r] == LAST_AGE || cnt_q[r] == '0) ? '0 : cnt_q[r] - AGE_W'(1);
`endif
        end
      end
      inflight_d = inflight_d + (REG_ADDR_WIDTH+1)'(valid_d[r]);
    end
  end
  // scoreboard state register; reset discards every entry at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      inflight_q <= '0;
      for (int r = 0; r < NREG; r++) begin
        age_q[r] <= '0;
`ifdef ID_SB_FWD_EN
        cnt_q[r] <= '0;
`endif
      end
    end else begin
      valid_q <= valid_d;
      inflight_q <= inflight_d;
      for (int r = 0; r < NREG; r++) begin
        age_q[r] <= age_d[r];
`ifdef ID_SB_FWD_EN
        cnt_q[r] <= cnt_d[r];
`endif
      end
    end
  end
endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed and random checks of id_scoreboard against a timestamp-based reference model
module tb_id_scoreboard;
  localparam int RAW = 5;
  localparam int NRP = 3;
  localparam int FS = 3;
  localparam int AW = 2;
`ifdef ID_SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  id_scoreboard_if #(.REG_ADDR_WIDTH(RAW), .NUM_RD_PORTS(NRP), .FWD_STAGES(FS), .AGE_W(AW)) sb ();
  id_scoreboard #(.REG_ADDR_WIDTH(RAW), .NUM_RD_PORTS(NRP), .FWD_STAGES(FS), .AGE_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .sb(sb)
  );
  int n_cmp = 0;
  int n_err = 0;
  int tick = 0;
  int t0 [32];
  int lat_m [32];
  function automatic int m_age(input int r);
    int a;
    a = tick - t0[r];
    return (a >= 1 && a <= FS) ? a : 0;
  endfunction
  function automatic int m_cnt(input int r);
    int c;
    c = ((lat_m[r] < FS - 1) ? lat_m[r] : FS - 1) - (m_age(r) - 1);
    return (m_age(r) == 0 || c < 0) ? 0 : c;
  endfunction
  function automatic logic m_stall(input logic [NRP-1:0] en, input logic [NRP*RAW-1:0] ad);
    logic s;
    s = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      int a;
      a = int'(ad[p*RAW +: RAW]);
      if (en[p] && a != 0 && m_age(a) != 0 && (!FWD || m_cnt(a) != 0)) s = 1'b1;
    end
    return s;
  endfunction
  function automatic logic [NRP*AW-1:0] m_fwd(input logic [NRP-1:0] en, input logic [NRP*RAW-1:0] ad);
    logic [NRP*AW-1:0] v;
    v = '0;
    for (int p = 0; p < NRP; p++) begin
      int a;
      a = int'(ad[p*RAW +: RAW]);
      if (FWD && en[p] && a != 0) v[p*AW +: AW] = AW'(m_age(a));
    end
    return v;
  endfunction
  function automatic int m_infl();
    int n;
    n = 0;
    for (int r = 1; r < 32; r++) if (m_age(r) != 0) n++;
    return n;
  endfunction
  function automatic logic [NRP*RAW-1:0] addr3(input int a0, input int a1, input int a2);
    return {RAW'(a2), RAW'(a1), RAW'(a0)};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    tick = 0;
    for (int r = 0; r < 32; r++) begin
      t0[r] = -1000;
      lat_m[r] = 0;
    end
  endtask
  task automatic step(input logic iss, input logic kil, input logic frz, input logic wr, input int wa,
                      input int lat, input logic [NRP-1:0] en, input logic [NRP*RAW-1:0] ad);
    logic es;
    sb.issue_i = iss;
    sb.kill_i = kil;
    sb.freeze_i = frz;
    sb.issue_wr_i = wr;
    sb.issue_waddr_i = RAW'(wa);
    sb.issue_lat_i = AW'(lat);
    sb.rd_en_i = en;
    sb.rd_addr_i = ad;
    @(negedge clk);
    es = m_stall(en, ad);
    check("stall", 32'(sb.stall_o), 32'(es));
    check("fwd_sel", 32'(sb.fwd_sel_o), 32'(m_fwd(en, ad)));
    check("inflight", 32'(sb.inflight_o), 32'(m_infl()));
    @(posedge clk);
    if (!frz) begin
      if (iss && !kil && !es && wr && wa != 0) begin
        t0[wa] = tick;
        lat_m[wa] = lat;
      end
      tick++;
    end
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0, '0);
  endtask
  initial begin
    sb.issue_i = 1'b0;
    sb.kill_i = 1'b0;
    sb.freeze_i = 1'b0;
    sb.issue_wr_i = 1'b0;
    sb.issue_waddr_i = '0;
    sb.issue_lat_i = '0;
    sb.rd_en_i = '0;
    sb.rd_addr_i = '0;
    model_reset();
    #12;
    check("reset_inflight", 32'(sb.inflight_o), 32'd0);
    check("reset_stall", 32'(sb.stall_o), 32'd0);
    check("reset_fwd", 32'(sb.fwd_sel_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1, 2, '0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 2, 0, '0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3, 1, '0, '0);
    check("pre_reset_inflight", 32'(sb.inflight_o), 32'd3);
    sb.issue_i = 1'b0;
    sb.rd_en_i = 3'b111;
    sb.rd_addr_i = addr3(1, 2, 3);
    #2 rst = 1'b1;
    #1;
    check("mid_reset_inflight", 32'(sb.inflight_o), 32'd0);
    check("mid_reset_stall", 32'(sb.stall_o), 32'd0);
    check("mid_reset_fwd", 32'(sb.fwd_sel_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 5, 0, '0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3'b001, addr3(5, 0, 0));
    idle(4);
    step(1'b1, 1'b0, 1'b0, 1'b1, 7, 1, '0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3'b100, addr3(0, 0, 7));
    idle(4);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3, 1, '0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3, 0, '0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3'b010, addr3(0, 3, 0));
    idle(4);
    step(1'b1, 1'b0, 1'b0, 1'b1, 9, 0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3'b001, addr3(9, 0, 0));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 6, 0, 3'b001, addr3(9, 0, 0));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3'b001, addr3(9, 0, 0));
    idle(4);
    step(1'b1, 1'b1, 1'b0, 1'b1, 4, 0, '0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3'b011, addr3(4, 0, 0));
    check("kill_x0_inflight", 32'(sb.inflight_o), 32'd0);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 2,
           $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3),
           NRP'($urandom), addr3($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
    end
    idle(5);
    check("drained_inflight", 32'(sb.inflight_o), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
